// File: rtl/expr_result_unpacker.sv
// Streams the 18 fields of a 90-bit vloghammer result word one per beat,
// each sign- or zero-extended to FIELD_W and tagged with its index.
module expr_result_unpacker #(
  parameter int FIELD_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [89:0]        in_word,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FIELD_W-1:0] out_data,
  output logic [4:0]         out_index,
  output logic               out_signed,
  output logic               out_last,
  output logic [15:0]        word_cnt
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state, state_nx;
  logic [89:0] hold;
  logic [4:0]  idx;
  logic        at_last;
  logic        take;
  logic        adv;

  assign at_last = (state == SEND) && (idx == 5'd17);
  assign take    = in_valid && in_ready;
  assign adv     = (state == SEND) && out_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: the default assignment at the top of each always_comb prevents latch inference.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = SEND;
      SEND: if (at_last && out_ready && !in_valid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: the holding register is cleared on reset so a discarded word leaves no stale data behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold     <= '0;
      idx      <= '0;
      word_cnt <= '0;
    end else begin
      if (take) begin
        hold <= in_word;
        idx  <= '0;
      end else if (adv) begin
        idx <= at_last ? 5'd0 : idx + 5'd1;
      end
      if (at_last && out_ready) word_cnt <= word_cnt + 16'd1;
    end
  end

  // Field decode: idx -> group of six (30 bits each) and position within the group.
  logic [1:0]  grp;
  logic [2:0]  pos;
  logic [6:0]  msb;
  logic [2:0]  fw;
  logic        sgn;
  logic [5:0]  top6;
  logic [15:0] mask;
  logic [15:0] ext;

  always_comb begin
    grp  = 2'd0;
    pos  = 3'(idx);
    if (idx >= 5'd12) begin
      grp = 2'd2;
      pos = 3'(idx - 5'd12);
    end else if (idx >= 5'd6) begin
      grp = 2'd1;
      pos = 3'(idx - 5'd6);
    end

    case (pos)
      3'd0:    begin msb = 7'd89; fw = 3'd4; end
      3'd1:    begin msb = 7'd85; fw = 3'd5; end
      3'd2:    begin msb = 7'd80; fw = 3'd6; end
      3'd3:    begin msb = 7'd74; fw = 3'd4; end
      3'd4:    begin msb = 7'd70; fw = 3'd5; end
      3'd5:    begin msb = 7'd65; fw = 3'd6; end
      default: begin msb = 7'd89; fw = 3'd4; end
    endcase
    case (grp)
      2'd1:    msb = msb - 7'd30;
      2'd2:    msb = msb - 7'd60;
      default: msb = msb;
    endcase
    sgn = (pos >= 3'd3);

    // Take six bits MSB-aligned on the field, then right-justify; top6[5] is the field's sign bit.
    top6 = hold[msb -: 6];
    mask = (16'd1 << fw) - 16'd1;
    ext  = {10'd0, top6 >> (3'd6 - fw)};
    if (sgn && top6[5]) ext = ext | ~mask;
  end

  always_comb begin
    in_ready   = (state == IDLE) || (at_last && out_ready);
    out_valid  = (state == SEND);
    out_data   = out_valid ? ext[FIELD_W-1:0] : '0;
    out_index  = out_valid ? idx : 5'd0;
    out_signed = out_valid && sgn;
    out_last   = at_last;
  end

endmodule

// File: doc/expr_result_unpacker.md
# expr_result_unpacker

Streaming reader for the 90-bit packed result bus of the vloghammer expression blocks, `y = {y0..y17}`. It accepts one packed word per valid/ready handshake and emits its 18 fields one per beat on a valid/ready output stream. Each field is sign- or zero-extended to a fixed width and tagged with its index. It sits between the DUT result capture and the regression checker, so results are compared field by field instead of as one opaque word.

## Interface
- `FIELD_W`, default 8: output field width; legal range 6..16.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `in_valid` input 1: `in_word` is valid.
- `in_ready` output 1: unpacker accepts `in_word` this cycle.
- `in_word` input 90: packed result word; y0 occupies bits [89:86].
- `out_valid` output 1: `out_data` / `out_index` / `out_signed` / `out_last` are valid.
- `out_ready` input 1: consumer accepts the current field.
- `out_data` output FIELD_W: extended field value.
- `out_index` output 5: field number, 0..17.
- `out_signed` output 1: 1 when the current field is a signed field.
- `out_last` output 1: asserted with field 17.
- `word_cnt` output 16: count of fully emitted words.

## Operation
- Field layout:
  - width(i) = 4 + (i mod 3), giving the repeating pattern 4,5,6.
  - Fields are packed MSB-first with no gaps: field 0 = [89:86], 1 = [85:81], 2 = [80:75], 3 = [74:71], 4 = [70:66], 5 = [65:60].
  - The pattern repeats every 6 fields, 30 bits lower each time. Field 17 = [5:0].
- Signedness: field i is signed when (i mod 6) >= 3, i.e. fields 3,4,5,9,10,11,15,16,17.
  - Signed fields are sign-extended to FIELD_W.
  - Unsigned fields are zero-extended to FIELD_W.
- State machine:
  - IDLE: `in_ready`=1, `out_valid`=0. On `in_valid`: capture `in_word` into the holding register, set idx=0, go to SEND.
  - SEND: `out_valid`=1, fields driven from the holding register at idx.
    - Each cycle with `out_ready`=1 advances idx by 1.
    - When field 17 is accepted and no new word is taken, return to IDLE and increment `word_cnt`.
- Back-to-back: in SEND with idx=17, `in_ready` = `out_ready` (combinational).
  - If `in_valid` is also 1, capture the new word, set idx=0, stay in SEND, and increment `word_cnt`.
  - Sustained throughput is 18 cycles per word with no bubble.
- `in_ready` is 0 in SEND for idx<17.
- Output stability: while `out_valid`=1 and `out_ready`=0, all out_* signals hold their values.
- `word_cnt` wraps from 65535 to 0.
- Reset, including mid-word:
  - State goes to IDLE, idx=0, `word_cnt`=0, holding register cleared.
  - A partially emitted word is discarded and not counted.
- Reset values of outputs: `in_ready`=1, `out_valid`=0, `out_data`=0, `out_index`=0, `out_signed`=0, `out_last`=0, `word_cnt`=0.

## Timing
- Latency: word accepted at edge N, field 0 presented in cycle N+1.
- One field per cycle when `out_ready`=1.
- Word accept to return to IDLE: 18 cycles minimum.
- `in_ready` has a combinational path from `out_ready` only. `out_*` come from registered state and the holding register.
- `out_index`, `out_signed`, `out_last` are decoded from registered idx.

## Test plan
- All-ones word (`in_word` = 90'h3FF...F), `out_ready`=1.
  - Beats 0/1/2 give 0x0F/0x1F/0x3F; beats 3/4/5 give 0xFF/0xFF/0xFF.
  - The same pattern repeats for 6..17.
  - `out_last` is asserted only on beat 17; `word_cnt`=1.
- Sparse word: bits [74:71]=4'b0111, bits [5:0]=6'b100000, all other bits 0.
  - Field 3 = 0x07 with `out_signed`=1.
  - Field 17 = 0xE0 with `out_last`=1.
  - All other fields = 0x00.
- Backpressure: `out_ready`=0 for 5 cycles when idx=7.
  - `out_data` / `out_index` stay constant (index 7).
  - After release, field 8 follows in the next cycle; `in_ready` stays 0 throughout.
- Back-to-back: `in_valid` held with two distinct words, `out_ready`=1.
  - 36 consecutive valid beats.
  - Field 0 of word 2 appears the cycle after field 17 of word 1.
  - `word_cnt`=2.
- Reset mid-word: assert `rst` when idx=9.
  - Next cycle: `out_valid`=0, `in_ready`=1, `word_cnt`=0.
  - The next accepted word starts at index 0.
- Wrap: preload 65535 completed words (or force the counter).
  - One more word makes `word_cnt`=0.
